div_unit: RTL and testbench

Multi-cycle 32-bit integer divider for the MIPS54 core's DIV/DIVU instructions. It runs alongside the single-cycle ALU. It accepts a start pulse with two operands, iterates one quotient bit per clock using restoring division, and returns quotient (LO) and remainder (HI) with a done pulse. The control unit stalls the pipeline while oBusy is high and writes HI/LO when oDone is high.

---
 rtl/div_unit.sv | 113 +++++++++++
 tb/tb_div_unit.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/div_unit.sv
// Multi-cycle restoring divider for DIV/DIVU: one quotient bit per clock,
// sign fix-up on the final iteration, divide-by-zero resolved in one cycle.
module div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             iClk,
  input  logic             iReset,
  input  logic             iStart,
  input  logic             iSigned,
  input  logic [WIDTH-1:0] iDividend,
  input  logic [WIDTH-1:0] iDivisor,
  output logic             oBusy,
  output logic             oDone,
  output logic [WIDTH-1:0] oQuotient,
  output logic [WIDTH-1:0] oRemainder,
  output logic             oDivByZero
);

  // state | meaning
  // IDLE  | waiting for a start
  // CALC  | iterating, or one-cycle bypass when the divisor is zero
  // DONE  | results valid for one cycle, new start may be accepted
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] rem_q, quo_q, dvs_q;
  logic [CW-1:0]    cnt_q;
  logic             neg_q_q, neg_r_q, dbz_q;
  logic [WIDTH-1:0] q_out_q, r_out_q;
  logic             dbz_out_q;

  logic             accept;
  logic [WIDTH-1:0] abs_dividend, abs_divisor;
  logic [WIDTH:0]   shifted, diff;
  logic [WIDTH-1:0] rem_nx, quo_nx;

  assign accept = iStart && (state_q != CALC);

  always_comb begin
    abs_dividend = (iSigned && iDividend[WIDTH-1]) ? -iDividend : iDividend;
    abs_divisor  = (iSigned && iDivisor[WIDTH-1])  ? -iDivisor  : iDivisor;
    shifted      = {rem_q, quo_q[WIDTH-1]};
    diff         = shifted - {1'b0, dvs_q};
    rem_nx       = diff[WIDTH] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
    quo_nx       = {quo_q[WIDTH-2:0], ~diff[WIDTH]};
  end

  always_ff @(posedge iClk) begin
    if (iReset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (iStart) state_d = CALC;
      CALC:    if (dbz_q || cnt_q == CNT_LAST) state_d = DONE;
      DONE:    state_d = iStart ? CALC : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    oBusy      = (state_q == CALC);
    oDone      = (state_q == DONE);
    oQuotient  = q_out_q;
    oRemainder = r_out_q;
    oDivByZero = dbz_out_q;
  end

  // On a zero divisor quo_q carries the raw dividend through the bypass cycle.
  always_ff @(posedge iClk) begin
    if (iReset) begin
      rem_q     <= '0;
      quo_q     <= '0;
      dvs_q     <= '0;
      cnt_q     <= '0;
      neg_q_q   <= 1'b0;
      neg_r_q   <= 1'b0;
      dbz_q     <= 1'b0;
      q_out_q   <= '0;
      r_out_q   <= '0;
      dbz_out_q <= 1'b0;
    end else if (accept) begin
      rem_q   <= '0;
      cnt_q   <= '0;
      dvs_q   <= abs_divisor;
      dbz_q   <= (iDivisor == '0);
      quo_q   <= (iDivisor == '0) ? iDividend : abs_dividend;
      neg_q_q <= iSigned && (iDividend[WIDTH-1] ^ iDivisor[WIDTH-1]);
      neg_r_q <= iSigned && iDividend[WIDTH-1];
    end else if (state_q == CALC) begin
      if (dbz_q) begin
        q_out_q   <= '1;
        r_out_q   <= quo_q;
        dbz_out_q <= 1'b1;
      end else begin
        rem_q <= rem_nx;
        quo_q <= quo_nx;
        cnt_q <= cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) begin
          q_out_q   <= neg_q_q ? -quo_nx : quo_nx;
          r_out_q   <= neg_r_q ? -rem_nx : rem_nx;
          dbz_out_q <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// Directed bench for div_unit: expected results from a behavioural model go
// into a queue at launch and are popped when oDone is seen.
module tb_div_unit;

  logic        iClk = 1'b0;
  logic        iReset, iStart, iSigned;
  logic [31:0] iDividend, iDivisor;
  logic        oBusy, oDone, oDivByZero;
  logic [31:0] oQuotient, oRemainder;

  typedef struct packed {
    logic [31:0] q;
    logic [31:0] r;
    logic        dbz;
  } exp_t;

  exp_t exp_q[$];
  exp_t last_exp;
  int   vectors = 0;
  int   miscompares = 0;

  div_unit #(.WIDTH(32)) dut (
    .iClk(iClk), .iReset(iReset), .iStart(iStart), .iSigned(iSigned),
    .iDividend(iDividend), .iDivisor(iDivisor),
    .oBusy(oBusy), .oDone(oDone), .oQuotient(oQuotient),
    .oRemainder(oRemainder), .oDivByZero(oDivByZero)
  );

  always #5 iClk = ~iClk;

  function automatic exp_t model(input logic s, input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    int sa, sb;
    sa = a;
    sb = b;
    if (b == 32'd0) begin
      e.q = 32'hFFFF_FFFF; e.r = a; e.dbz = 1'b1;
    end else if (!s) begin
      e.q = a / b; e.r = a % b; e.dbz = 1'b0;
    end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      e.q = 32'h8000_0000; e.r = 32'd0; e.dbz = 1'b0;
    end else begin
      e.q = sa / sb; e.r = sa % sb; e.dbz = 1'b0;
    end
    return e;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // Caller sits just after a negedge; returns just after the negedge following E0.
  task automatic launch(input logic s, input logic [31:0] a, input logic [31:0] b,
                        input bit push, input string tag);
    iSigned = s; iDividend = a; iDivisor = b; iStart = 1'b1;
    if (push) exp_q.push_back(model(s, a, b));
    @(posedge iClk);
    @(negedge iClk);
    iStart = 1'b0;
    check({tag, "_busy_after_start"}, {31'd0, oBusy}, 32'd1);
    check({tag, "_done_after_start"}, {31'd0, oDone}, 32'd0);
  endtask

  task automatic finish(input int lat, input string tag, input int inj);
    int   n = 0;
    bit   busy_ok = 1'b1;
    exp_t e;
    while (!oDone && n < 60) begin
      if (n == inj) begin
        iStart = 1'b1; iSigned = ~iSigned;
        iDividend = 32'h5555_5555; iDivisor = 32'd3;
      end
      @(posedge iClk);
      @(negedge iClk);
      n++;
      iStart = 1'b0;
      if (!oDone && !oBusy) busy_ok = 1'b0;
    end
    check({tag, "_latency"}, n, lat);
    check({tag, "_busy_held"}, {31'd0, busy_ok}, 32'd1);
    check({tag, "_busy_at_done"}, {31'd0, oBusy}, 32'd0);
    e = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
    last_exp = e;
    check({tag, "_quotient"}, oQuotient, e.q);
    check({tag, "_remainder"}, oRemainder, e.r);
    check({tag, "_divbyzero"}, {31'd0, oDivByZero}, {31'd0, e.dbz});
  endtask

  initial begin
    int done_seen;
    iReset = 1'b1; iStart = 1'b0; iSigned = 1'b0; iDividend = '0; iDivisor = '0;
    repeat (3) @(posedge iClk);
    @(negedge iClk);
    iReset = 1'b0;
    check("rst_busy", {31'd0, oBusy}, 32'd0);
    check("rst_done", {31'd0, oDone}, 32'd0);
    check("rst_quotient", oQuotient, 32'd0);
    check("rst_remainder", oRemainder, 32'd0);
    check("rst_dbz", {31'd0, oDivByZero}, 32'd0);
    @(negedge iClk);

    launch(1'b0, 32'd100, 32'd7, 1, "divu_100_7");           finish(32, "divu_100_7", -1);
    check("divu_100_7_const_q", oQuotient, 32'd14);
    check("divu_100_7_const_r", oRemainder, 32'd2);
    @(negedge iClk);
    launch(1'b1, 32'hFFFF_FFF9, 32'd2, 1, "div_m7_2");       finish(32, "div_m7_2", -1);
    @(negedge iClk);
    launch(1'b1, 32'd7, 32'hFFFF_FFFE, 1, "div_7_m2");       finish(32, "div_7_m2", -1);
    @(negedge iClk);
    launch(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1, "div_ovf"); finish(32, "div_ovf", -1);
    @(negedge iClk);
    launch(1'b0, 32'hFFFF_FFFF, 32'd1, 1, "divu_max_1");     finish(32, "divu_max_1", -1);
    @(negedge iClk);
    launch(1'b1, 32'h1234_5678, 32'd0, 1, "div_by_zero");    finish(1, "div_by_zero", -1);
    @(negedge iClk);
    launch(1'b1, 32'h8000_0000, 32'd1, 1, "div_min_1");      finish(32, "div_min_1", -1);
    @(negedge iClk);

    // Start pulse sampled at E10 must be ignored; then results hold after DONE.
    launch(1'b0, 32'd1000, 32'd33, 1, "ignore_mid");         finish(32, "ignore_mid", 9);
    @(posedge iClk);
    @(negedge iClk);
    check("hold_done_low", {31'd0, oDone}, 32'd0);
    check("hold_busy_low", {31'd0, oBusy}, 32'd0);
    check("hold_quotient", oQuotient, last_exp.q);
    check("hold_remainder", oRemainder, last_exp.r);

    // Back-to-back: second start issued in the DONE cycle.
    launch(1'b1, 32'hFFFF_FF9C, 32'd9, 1, "b2b_first");      finish(32, "b2b_first", -1);
    launch(1'b0, 32'd123456789, 32'd1000, 1, "b2b_second");
    check("b2b_results_stable_q", oQuotient, last_exp.q);
    finish(32, "b2b_second", -1);
    @(negedge iClk);
    launch(1'b0, 32'hDEAD_BEEF, 32'd0, 1, "divu_by_zero");   finish(1, "divu_by_zero", -1);
    @(negedge iClk);

    // Reset mid-CALC discards the division.
    launch(1'b1, 32'd5000, 32'd7, 0, "rst_mid");
    repeat (14) begin @(posedge iClk); @(negedge iClk); end
    iReset = 1'b1;
    @(posedge iClk);
    @(negedge iClk);
    iReset = 1'b0;
    check("rst_mid_busy", {31'd0, oBusy}, 32'd0);
    check("rst_mid_done", {31'd0, oDone}, 32'd0);
    check("rst_mid_quotient", oQuotient, 32'd0);
    check("rst_mid_remainder", oRemainder, 32'd0);
    check("rst_mid_dbz", {31'd0, oDivByZero}, 32'd0);
    done_seen = 0;
    repeat (40) begin
      @(posedge iClk);
      @(negedge iClk);
      if (oDone || oBusy) done_seen++;
    end
    check("rst_mid_no_done", done_seen, 32'd0);
    check("scoreboard_empty", exp_q.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
